jt6295_rom_arb: RTL and testbench

//  Shares the single external sample ROM port between five requesters: the phrase-table reader
//  (requester 4, 10-bit header addresses) and the four ADPCM channel fetchers (requesters 0-3).

---
 rtl/jt6295_rom_arb.sv | 178 +++++++++++++++++
 tb/tb_jt6295_rom_arb.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt6295_rom_arb.sv
// jt6295_rom_arb
// Shares the external sample ROM port between the phrase-table reader and the
// four ADPCM channel fetchers. Each requester owns a one-byte tag/data cache,
// so repeated reads of the same address never touch the ROM. The table reader
// has fixed priority; channels are served round-robin.
module jt6295_rom_arb #(
    parameter int AW     = 18,   // ROM byte address width
    parameter int HW     = 10,   // phrase table address width (zero-extended to AW)
    parameter int SETTLE = 1     // cycles rom_ok is ignored after rom_addr changes, 0..3
) (
    input  logic              clk,
    input  logic              rst,
    // phrase table reader
    input  logic              hdr_cs,
    input  logic [HW-1:0]     hdr_addr,
    output logic [7:0]        hdr_data,
    output logic              hdr_ok,
    // channel fetchers
    input  logic [3:0]        ch_cs,
    input  logic [4*AW-1:0]   ch_addr,
    output logic [4*8-1:0]    ch_data,
    output logic [3:0]        ch_ok,
    // external ROM
    output logic [AW-1:0]     rom_addr,
    output logic              rom_cs,
    input  logic [7:0]        rom_data,
    input  logic              rom_ok
);

    localparam int NREQ = 5;
    localparam int HDR  = 4;   // requester index of the table reader

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    // Requester views: index 0..3 are channels, 4 is the table reader
    logic [NREQ-1:0]         req_cs;
    logic [NREQ-1:0][AW-1:0] req_addr;

    // Cache state
    logic [NREQ-1:0][AW-1:0] tag_q;
    logic [NREQ-1:0][7:0]    data_q;
    logic [NREQ-1:0]         valid_q;
    logic [NREQ-1:0]         hit;
    logic [NREQ-1:0]         pending;

    // Fetch FSM state
    state_t                  state_q, state_d;
    logic [2:0]              gnt_q, gnt_d;
    logic [AW-1:0]           rom_addr_q, rom_addr_d;
    logic                    rom_cs_q, rom_cs_d;
    logic [1:0]              settle_q, settle_d;
    logic [1:0]              rr_q, rr_d;
    logic                    capture;

    // Arbitration result for the current cycle
    logic [2:0]              pick;
    logic                    ch_found;
    logic [1:0]              rr_idx;

    assign req_cs             = {hdr_cs, ch_cs};
    assign req_addr[HDR]      = {{(AW-HW){1'b0}}, hdr_addr};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ch_map
            assign req_addr[gi]       = ch_addr[AW*gi +: AW];
            assign ch_data[8*gi +: 8] = data_q[gi];
            assign ch_ok[gi]          = req_cs[gi] & hit[gi];
        end
    endgenerate

    // Hit/pending per requester; ok follows the live address so it drops as soon as addr moves
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_hit
            assign hit[gi]     = valid_q[gi] && (tag_q[gi] == req_addr[gi]);
            assign pending[gi] = req_cs[gi] & ~hit[gi];
        end
    endgenerate

    assign hdr_data = data_q[HDR];
    assign hdr_ok   = req_cs[HDR] & hit[HDR];
    assign rom_addr = rom_addr_q;
    assign rom_cs   = rom_cs_q;

    // Arbiter: table reader first, otherwise first pending channel from the rr pointer upward
    always_comb begin
        pick     = 3'(HDR);
        ch_found = 1'b0;
        rr_idx   = rr_q;
        if (!pending[HDR]) begin
            for (int i = 0; i < 4; i++) begin
                rr_idx = rr_q + 2'(i);
                if (!ch_found && pending[rr_idx]) begin
                    ch_found = 1'b1;
                    pick     = {1'b0, rr_idx};
                end
            end
        end
    end

    // Fetch FSM next-state: one IDLE cycle per grant, then WAIT until a settled rom_ok
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rom_addr_d = rom_addr_q;
        rom_cs_d   = rom_cs_q;
        settle_d   = settle_q;
        rr_d       = rr_q;
        capture    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pending) begin
                    gnt_d      = pick;
                    rom_addr_d = req_addr[pick];
                    rom_cs_d   = 1'b1;
                    settle_d   = 2'(SETTLE);
                    state_d    = ST_WAIT;
                    if (pick != 3'(HDR)) begin
                        rr_d = pick[1:0] + 2'd1;
                    end
                end
            end
            ST_WAIT: begin
                // rom_ok may still reflect the previous address right after rom_addr moved
                if (settle_q != 2'd0) begin
                    settle_d = settle_q - 2'd1;
                end else if (rom_ok) begin
                    capture  = 1'b1;
                    rom_cs_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                rom_cs_d = 1'b0;
            end
        endcase
    end

    // Fetch FSM registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 3'd0;
            rom_addr_q <= '0;
            rom_cs_q   <= 1'b0;
            settle_q   <= 2'd0;
            rr_q       <= 2'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rom_addr_q <= rom_addr_d;
            rom_cs_q   <= rom_cs_d;
            settle_q   <= settle_d;
            rr_q       <= rr_d;
        end
    end

    // Cache fill: the latched fetch address is cached even if the requester has moved on
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q   <= '0;
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (capture && gnt_q == 3'(k)) begin
                    tag_q[k]   <= rom_addr_q;
                    data_q[k]  <= rom_data;
                    valid_q[k] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jt6295_rom_arb.sv
// Testbench for jt6295_rom_arb: directed scenarios followed by randomized
// traffic, all checked against a cycle-level behavioural model of the caches,
// the priority/round-robin grant order and the settle window.
module tb_jt6295_rom_arb;

    localparam int AW     = 18;
    localparam int HW     = 10;
    localparam int SETTLE = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              hdr_cs;
    logic [HW-1:0]     hdr_addr;
    logic [7:0]        hdr_data;
    logic              hdr_ok;
    logic [3:0]        ch_cs;
    logic [4*AW-1:0]   ch_addr;
    logic [31:0]       ch_data;
    logic [3:0]        ch_ok;
    logic [AW-1:0]     rom_addr;
    logic              rom_cs;
    logic [7:0]        rom_data;
    logic              rom_ok;

    jt6295_rom_arb #(.AW(AW), .HW(HW), .SETTLE(SETTLE)) dut (
        .clk      (clk),
        .rst      (rst),
        .hdr_cs   (hdr_cs),
        .hdr_addr (hdr_addr),
        .hdr_data (hdr_data),
        .hdr_ok   (hdr_ok),
        .ch_cs    (ch_cs),
        .ch_addr  (ch_addr),
        .ch_data  (ch_data),
        .ch_ok    (ch_ok),
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_data (rom_data),
        .rom_ok   (rom_ok)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Stimulus state (index 4 = table reader, addresses kept zero-extended)
    logic [4:0]    cs_v;
    logic [AW-1:0] addr_v [5];
    logic          rst_v;
    logic          rom_ok_v;
    bit            chk_en;

    // Reference model
    bit            m_valid [5];
    logic [AW-1:0] m_tag   [5];
    logic [7:0]    m_data  [5];
    bit            m_busy;
    int            m_gnt;
    logic [AW-1:0] m_addr;
    int            m_wait;
    int            m_rr;

    // ROM model: data lags the address by one cycle, so an early capture sees a stale byte
    logic [AW-1:0] last_rom_addr;
    logic          prev_rom_cs;
    logic [AW-1:0] fetch_q [$];

    function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
        logic [7:0] t;
        if (a == 18'h12345) return 8'hA5;
        t = a[7:0] ^ (a[15:8] * 8'd7) ^ {a[17:16], 6'h1c};
        return t;
    endfunction

    function automatic bit m_hit(input int k);
        return m_valid[k] && (m_tag[k] == addr_v[k]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            m_valid[k] = 0;
            m_tag[k]   = '0;
            m_data[k]  = 8'h00;
        end
        m_busy = 0;
        m_gnt  = 0;
        m_addr = '0;
        m_wait = 0;
        m_rr   = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model
    task automatic step();
        bit [4:0] pend;
        bit       found;
        int       c;
        @(negedge clk);
        rst      = rst_v;
        hdr_cs   = cs_v[4];
        hdr_addr = addr_v[4][HW-1:0];
        ch_cs    = cs_v[3:0];
        for (int k = 0; k < 4; k++) ch_addr[AW*k +: AW] = addr_v[k];
        rom_ok   = rom_ok_v;
        rom_data = rom_byte(last_rom_addr);
        #1;
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("ch_ok[%0d]", k), 32'(ch_ok[k]), 32'(cs_v[k] && m_hit(k)));
                check($sformatf("ch_data[%0d]", k), 32'(ch_data[8*k +: 8]), 32'(m_data[k]));
            end
            check("hdr_ok", 32'(hdr_ok), 32'(cs_v[4] && m_hit(4)));
            check("hdr_data", 32'(hdr_data), 32'(m_data[4]));
            check("rom_cs", 32'(rom_cs), 32'(m_busy));
            if (m_busy) check("rom_addr", 32'(rom_addr), 32'(m_addr));
        end
        if (rom_cs === 1'b1 && prev_rom_cs !== 1'b1) fetch_q.push_back(rom_addr);
        prev_rom_cs   = rom_cs;
        last_rom_addr = rom_addr;
        // model transition for the upcoming edge
        if (rst_v) begin
            model_reset();
        end else if (m_busy) begin
            m_wait++;
            if (m_wait > SETTLE && rom_ok_v) begin
                m_valid[m_gnt] = 1;
                m_tag[m_gnt]   = m_addr;
                m_data[m_gnt]  = rom_byte(m_addr);
                m_busy         = 0;
            end
        end else begin
            for (int k = 0; k < 5; k++) pend[k] = cs_v[k] && !m_hit(k);
            if (pend != 5'd0) begin
                found = 0;
                if (pend[4]) begin
                    m_gnt = 4;
                    found = 1;
                end
                for (int i = 0; i < 4; i++) begin
                    c = (m_rr + i) % 4;
                    if (!found && pend[c]) begin
                        m_gnt = c;
                        found = 1;
                    end
                end
                m_addr = addr_v[m_gnt];
                m_busy = 1;
                m_wait = 0;
                if (m_gnt != 4) m_rr = (m_gnt + 1) % 4;
            end
        end
    endtask

    task automatic do_reset();
        rst_v = 1;
        cs_v  = 5'd0;
        step();
        rst_v = 0;
        step();
        fetch_q.delete();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_rom_cs(input string tag);
        int guard;
        guard = 0;
        while (rom_cs !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        if (guard >= 20) check({tag, " timeout"}, 32'd0, 32'd1);
    endtask

    function automatic logic [AW-1:0] ch_pool(input int k, input int idx);
        return {2'(k), 8'(idx * 37 + 3), 8'(idx * 91 + k * 17)};
    endfunction

    initial begin
        int lat;
        logic [AW-1:0] exp_a [4];
        rst = 1; hdr_cs = 0; hdr_addr = '0; ch_cs = '0; ch_addr = '0;
        rom_data = '0; rom_ok = 0;
        cs_v = '0; rst_v = 1; rom_ok_v = 1; chk_en = 0;
        for (int k = 0; k < 5; k++) addr_v[k] = '0;
        last_rom_addr = '0; prev_rom_cs = 0;
        model_reset();

        // Reset then idle
        step();
        chk_en = 1;
        do_reset();
        run(3);
        check("reset rom_addr", 32'(rom_addr), 32'd0);
        check("reset rom_cs", 32'(rom_cs), 32'd0);
        $display("txn reset/idle: rom_cs=%0b ch_ok=%b hdr_ok=%0b", rom_cs, ch_ok, hdr_ok);

        // Single channel fetch, then cache hits
        addr_v[0] = 18'h12345;
        cs_v      = 5'b00001;
        lat = 0;
        step();
        while (ch_ok[0] !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check("ch0 latency max", 32'(lat <= 3 + SETTLE), 32'd1);
        check("ch0 latency min", 32'(lat >= 2 + SETTLE), 32'd1);
        check("ch0 data A5", 32'(ch_data[7:0]), 32'hA5);
        run(10);
        check("ch0 single fetch", 32'(fetch_q.size()), 32'd1);
        $display("txn ch0 fetch: latency=%0d data=%0h fetches=%0d", lat, ch_data[7:0], fetch_q.size());

        // Four simultaneous channel requests: round-robin from 0
        do_reset();
        for (int k = 0; k < 4; k++) begin
            exp_a[k]  = ch_pool(k, k + 1);
            addr_v[k] = exp_a[k];
        end
        cs_v = 5'b01111;
        run(30);
        check("rr fetch count", 32'(fetch_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < fetch_q.size(); k++)
            check($sformatf("rr order %0d", k), 32'(fetch_q[k]), 32'(exp_a[k]));
        check("rr all ok", 32'(ch_ok), 32'hF);
        $display("txn rr 4ch: fetches=%0d ch_ok=%b", fetch_q.size(), ch_ok);

        // Table reader beats pending channels
        do_reset();
        addr_v[1] = ch_pool(1, 2);
        addr_v[2] = ch_pool(2, 3);
        addr_v[4] = 18'h8;
        cs_v = 5'b10110;
        run(25);
        check("hdr first", (fetch_q.size() > 0) ? 32'(fetch_q[0]) : 32'hFFFFFFFF, 32'h8);
        check("hdr ok", 32'(hdr_ok), 32'd1);
        $display("txn hdr priority: first=%0h hdr_data=%0h", (fetch_q.size() > 0) ? fetch_q[0] : '1, hdr_data);

        // Channel 2 changes address during WAIT
        do_reset();
        cs_v = 5'b00100;
        addr_v[2] = ch_pool(2, 4);
        wait_rom_cs("ch2 first");
        addr_v[2] = ch_pool(2, 5);
        run(15);
        check("ch2 fetch count", 32'(fetch_q.size()), 32'd2);
        if (fetch_q.size() == 2) begin
            check("ch2 old addr", 32'(fetch_q[0]), 32'(ch_pool(2, 4)));
            check("ch2 new addr", 32'(fetch_q[1]), 32'(ch_pool(2, 5)));
        end
        check("ch2 data new", 32'(ch_data[23:16]), 32'(rom_byte(ch_pool(2, 5))));
        $display("txn ch2 addr change: fetches=%0d ok=%0b", fetch_q.size(), ch_ok[2]);

        // Reset in the middle of WAIT
        do_reset();
        rom_ok_v  = 0;
        addr_v[0] = ch_pool(0, 6);
        cs_v      = 5'b00001;
        wait_rom_cs("midwait");
        step();
        rst_v = 1;
        step();
        rst_v = 0;
        step();
        check("midwait rom_cs", 32'(rom_cs), 32'd0);
        check("midwait rom_addr", 32'(rom_addr), 32'd0);
        $display("txn reset mid-WAIT: rom_cs=%0b rom_addr=%0h", rom_cs, rom_addr);
        cs_v = '0;
        rom_ok_v = 1;
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 5; k++) begin
                if (cs_v[k] && !m_hit(k)) begin
                    if (k < 4 && $urandom_range(0, 49) == 0) addr_v[k] = ch_pool(k, $urandom_range(0, 5));
                end else if (cs_v[k]) begin
                    if ($urandom_range(0, 1) == 0) cs_v[k] = 0;
                    else addr_v[k] = (k == 4) ? 18'($urandom_range(0, 4) * 6) : ch_pool(k, $urandom_range(0, 5));
                end else if ($urandom_range(0, 9) < 3) begin
                    cs_v[k]   = 1;
                    addr_v[k] = (k == 4) ? 18'($urandom_range(0, 4) * 6) : ch_pool(k, $urandom_range(0, 5));
                end
            end
            rom_ok_v = ($urandom_range(0, 9) < 7);
            rst_v    = ($urandom_range(0, 499) == 0);
            step();
            if (n % 500 == 499) $display("txn random block %0d: fetches so far=%0d", n / 500, fetch_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
